// File: rtl/snoop_bus_arbiter_if.sv
// Coherence bus bundle between the per-core cache controllers and the snoop bus arbiter.
// The slave modport is the arbiter; the master modport is the core-side bench/cluster.
interface snoop_bus_arbiter_if #(
    parameter int NUM_CPU = 4,
    parameter int ADDR_W  = 11
);
    localparam int SRC_W = (NUM_CPU > 1) ? $clog2(NUM_CPU) : 1;

    logic [NUM_CPU-1:0]        read_miss;
    logic [NUM_CPU-1:0]        write_miss;
    logic [NUM_CPU-1:0]        invalidate;
    logic [NUM_CPU*ADDR_W-1:0] addr_in;
    logic [NUM_CPU-1:0]        search_found;

    logic [NUM_CPU-1:0]        grant;
    logic [ADDR_W-1:0]         addr_out;
    logic [NUM_CPU-1:0]        search;
    logic                      datasel;
    logic [SRC_W-1:0]          src_id;
    logic [NUM_CPU-1:0]        invalidate_tag;
    logic [NUM_CPU-1:0]        wback_dmem;
    logic [NUM_CPU-1:0]        invalidate_dmem;
    logic [NUM_CPU-1:0]        done;
    logic                      busy;

    modport slave (
        input  read_miss, write_miss, invalidate, addr_in, search_found,
        output grant, addr_out, search, datasel, src_id,
               invalidate_tag, wback_dmem, invalidate_dmem, done, busy
    );

    modport master (
        output read_miss, write_miss, invalidate, addr_in, search_found,
        input  grant, addr_out, search, datasel, src_id,
               invalidate_tag, wback_dmem, invalidate_dmem, done, busy
    );
endinterface

// File: rtl/snoop_bus_arbiter.sv
// Round-robin snoop bus arbiter for NUM_CPU private caches: read via peer forward or dmem,
// write-miss write-back, and upgrade invalidate. Optional counters under BUS_PERF_CNT_EN.
module snoop_bus_arbiter #(
    parameter int NUM_CPU  = 4,
    parameter int ADDR_W   = 11,
    parameter int MEM_LAT  = 4,
    parameter int XFER_CYC = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    snoop_bus_arbiter_if.slave  bus
`ifdef BUS_PERF_CNT_EN
    ,
    output logic [15:0]         txn_cnt,
    output logic [15:0]         snoop_hit_cnt
`endif
);
    localparam int SRC_W   = (NUM_CPU > 1) ? $clog2(NUM_CPU) : 1;
    localparam int CNT_MAX = (MEM_LAT > XFER_CYC) ? MEM_LAT : XFER_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_SNOOP      = 3'd1;
    localparam logic [2:0] S_SNOOP_RSP  = 3'd2;
    localparam logic [2:0] S_XFER       = 3'd3;
    localparam logic [2:0] S_MEM_WAIT   = 3'd4;
    localparam logic [2:0] S_WRITE_MISS = 3'd5;
    localparam logic [2:0] S_INVAL      = 3'd6;

    logic [2:0]         state;
    logic [SRC_W-1:0]   rr_ptr;
    logic [SRC_W-1:0]   id;
    logic [SRC_W-1:0]   src_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [CNT_W-1:0]   cnt;

    logic [NUM_CPU-1:0] req;
    logic [NUM_CPU-1:0] owner_oh;
    logic [NUM_CPU-1:0] hits;
    logic               win_found;
    logic [SRC_W-1:0]   win_id;
    logic [SRC_W-1:0]   hit_id;
    logic [SRC_W-1:0]   rr_next;

    assign req     = bus.read_miss | bus.write_miss | bus.invalidate;
    assign hits    = bus.search_found & ~owner_oh;
    assign rr_next = (id == SRC_W'(NUM_CPU - 1)) ? '0 : id + 1'b1;

    // Scan downward so the candidate closest to rr_ptr is the last (winning) assignment.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        hit_id    = '0;
        owner_oh  = '0;
        for (int k = NUM_CPU - 1; k >= 0; k--) begin
            if (req[SRC_W'((int'(rr_ptr) + k) % NUM_CPU)]) begin
                win_found = 1'b1;
                win_id    = SRC_W'((int'(rr_ptr) + k) % NUM_CPU);
            end
        end
        for (int i = NUM_CPU - 1; i >= 0; i--) begin
            if (hits[i]) hit_id = SRC_W'(i);
            owner_oh[i] = (id == SRC_W'(i));
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees
    // the pre-edge values of the others regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            rr_ptr <= '0;
            id     <= '0;
            src_q  <= '0;
            addr_q <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        id     <= win_id;
                        addr_q <= bus.addr_in[win_id*ADDR_W +: ADDR_W];
                        cnt    <= CNT_W'(MEM_LAT - 1);
                        if (bus.read_miss[win_id])
                            state <= (NUM_CPU == 1) ? S_MEM_WAIT : S_SNOOP;
                        else if (bus.write_miss[win_id])
                            state <= S_WRITE_MISS;
                        else
                            state <= S_INVAL;
                    end
                end
                S_SNOOP: state <= S_SNOOP_RSP;
                S_SNOOP_RSP: begin
                    if (|hits) begin
                        src_q <= hit_id;
                        cnt   <= CNT_W'(XFER_CYC - 1);
                        state <= S_XFER;
                    end else begin
                        cnt   <= CNT_W'(MEM_LAT - 1);
                        state <= S_MEM_WAIT;
                    end
                end
                S_XFER, S_MEM_WAIT: begin
                    if (cnt == '0) begin
                        rr_ptr <= rr_next;
                        state  <= S_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_WRITE_MISS, S_INVAL: begin
                    rr_ptr <= rr_next;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from state only; the arbitration cycle itself drives nothing.
    always_comb begin
        bus.grant           = '0;
        bus.addr_out        = '0;
        bus.search          = '0;
        bus.datasel         = 1'b0;
        bus.src_id          = '0;
        bus.invalidate_tag  = '0;
        bus.wback_dmem      = '0;
        bus.invalidate_dmem = '0;
        bus.done            = '0;
        bus.busy            = (state != S_IDLE);
        if (state != S_IDLE) begin
            bus.grant    = owner_oh;
            bus.addr_out = addr_q;
        end
        case (state)
            S_SNOOP: bus.search = ~owner_oh;
            S_XFER: begin
                bus.datasel = 1'b1;
                bus.src_id  = src_q;
                if (cnt == '0) bus.done = owner_oh;
            end
            S_MEM_WAIT: if (cnt == '0) bus.done = owner_oh;
            S_WRITE_MISS: begin
                bus.invalidate_tag = ~owner_oh;
                bus.wback_dmem     = owner_oh;
                bus.done           = owner_oh;
            end
            S_INVAL: begin
                bus.invalidate_tag  = ~owner_oh;
                bus.invalidate_dmem = owner_oh;
                bus.done            = owner_oh;
            end
            default: ;
        endcase
    end

`ifdef BUS_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_cnt       <= '0;
            snoop_hit_cnt <= '0;
        end else begin
            if (|bus.done && txn_cnt != 16'hFFFF)
                txn_cnt <= txn_cnt + 1'b1;
            if (state == S_SNOOP_RSP && |hits && snoop_hit_cnt != 16'hFFFF)
                snoop_hit_cnt <= snoop_hit_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Directed bench for snoop_bus_arbiter: a transaction-level model checked every cycle,
// plus literal expectations from hand-worked scenarios.
module tb_snoop_bus_arbiter;
    localparam int NUM_CPU  = 4;
    localparam int ADDR_W   = 11;
    localparam int MEM_LAT  = 4;
    localparam int XFER_CYC = 2;
    localparam int SRC_W    = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    snoop_bus_arbiter_if #(.NUM_CPU(NUM_CPU), .ADDR_W(ADDR_W)) bus ();

`ifdef BUS_PERF_CNT_EN
    logic [15:0] txn_cnt, snoop_hit_cnt;
`endif

    snoop_bus_arbiter #(
        .NUM_CPU(NUM_CPU), .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT), .XFER_CYC(XFER_CYC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef BUS_PERF_CNT_EN
        ,
        .txn_cnt       (txn_cnt),
        .snoop_hit_cnt (snoop_hit_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t: timed out waiting on DUT", name, $time);
    endtask

    // ---------------- transaction-level reference model ----------------
    typedef enum {M_READ, M_WRITE, M_INVAL} op_t;
    typedef struct {
        logic [NUM_CPU-1:0] grant;
        logic [ADDR_W-1:0]  addr_out;
        logic [NUM_CPU-1:0] search;
        logic               datasel;
        logic [SRC_W-1:0]   src_id;
        logic [NUM_CPU-1:0] inv_tag;
        logic [NUM_CPU-1:0] wback;
        logic [NUM_CPU-1:0] inv_dmem;
        logic [NUM_CPU-1:0] done;
        logic               busy;
    } exp_t;

    bit                 m_busy;
    int                 m_t, m_owner, m_len, m_src, m_rr;
    bit                 m_xfer;
    op_t                m_op;
    logic [ADDR_W-1:0]  m_addr;
    int                 m_txn, m_hits;

    always @(negedge clk) begin
        exp_t               e;
        logic [NUM_CPU-1:0] hitv;
        e = '{default: '0};
        if (!rst_n) begin
            m_busy = 0; m_rr = 0; m_txn = 0; m_hits = 0;
        end
`ifdef BUS_PERF_CNT_EN
        check("txn_cnt", txn_cnt, m_txn);
        check("snoop_hit_cnt", snoop_hit_cnt, m_hits);
`endif
        if (rst_n && m_busy) begin
            m_t++;
            e.grant    = NUM_CPU'(1) << m_owner;
            e.addr_out = m_addr;
            e.busy     = 1'b1;
            case (m_op)
                M_READ: begin
                    if (m_t == 1) e.search = ~e.grant;
                    if (m_t == 2) begin
                        hitv = bus.search_found & ~e.grant;
                        if (hitv != 0) begin
                            m_xfer = 1;
                            for (int i = NUM_CPU - 1; i >= 0; i--) if (hitv[i]) m_src = i;
                            m_len = 2 + XFER_CYC;
                            m_hits++;
                        end else begin
                            m_xfer = 0;
                            m_len  = 2 + MEM_LAT;
                        end
                    end
                    if (m_t >= 3) begin
                        e.datasel = m_xfer;
                        e.src_id  = m_xfer ? SRC_W'(m_src) : '0;
                    end
                    if (m_t == m_len) e.done = e.grant;
                end
                M_WRITE: begin
                    e.inv_tag = ~e.grant;
                    e.wback   = e.grant;
                    e.done    = e.grant;
                end
                default: begin
                    e.inv_tag  = ~e.grant;
                    e.inv_dmem = e.grant;
                    e.done     = e.grant;
                end
            endcase
            if (e.done != 0) begin
                m_busy = 0;
                m_rr   = (m_owner + 1) % NUM_CPU;
                m_txn++;
            end
        end else if (rst_n) begin
            for (int k = 0; k < NUM_CPU && !m_busy; k++) begin
                int i;
                i = (m_rr + k) % NUM_CPU;
                if (bus.read_miss[i] || bus.write_miss[i] || bus.invalidate[i]) begin
                    m_busy  = 1; m_t = 0; m_owner = i; m_len = 0;
                    m_addr  = bus.addr_in[i*ADDR_W +: ADDR_W];
                    m_op    = bus.read_miss[i] ? M_READ : (bus.write_miss[i] ? M_WRITE : M_INVAL);
                end
            end
        end
        check("grant", bus.grant, e.grant);
        check("addr_out", bus.addr_out, e.addr_out);
        check("search", bus.search, e.search);
        check("datasel", bus.datasel, e.datasel);
        if (e.datasel || !e.busy) check("src_id", bus.src_id, e.src_id);
        check("invalidate_tag", bus.invalidate_tag, e.inv_tag);
        check("wback_dmem", bus.wback_dmem, e.wback);
        check("invalidate_dmem", bus.invalidate_dmem, e.inv_dmem);
        check("done", bus.done, e.done);
        check("busy", bus.busy, e.busy);
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!bus.busy) return;
        end
        fail_timeout(name);
    endtask

    // Counts negedges (first one included) until a done pulse, recording what was seen.
    task automatic observe(input string name, output int n, output int n_search,
                           output logic [NUM_CPU-1:0] search_v, output int n_ds,
                           output logic [SRC_W-1:0] src_v, output logic [NUM_CPU-1:0] done_v,
                           output logic [ADDR_W-1:0] addr_v);
        n = 0; n_search = 0; n_ds = 0; search_v = '0; src_v = '0; done_v = '0; addr_v = '0;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            if (bus.search != 0) begin n_search++; search_v = bus.search; end
            if (bus.datasel) begin n_ds++; src_v = bus.src_id; end
            if (bus.done != 0) begin
                n = c; done_v = bus.done; addr_v = bus.addr_out;
                return;
            end
        end
        fail_timeout(name);
    endtask

    initial begin
        int                 n, n_search, n_ds, got;
        logic [NUM_CPU-1:0] search_v, done_v, prev;
        logic [NUM_CPU-1:0] order [5];
        logic [SRC_W-1:0]   src_v;
        logic [ADDR_W-1:0]  addr_v;

        rst_n            = 1'b0;
        bus.read_miss    = '1;
        bus.write_miss   = '1;
        bus.invalidate   = '1;
        bus.search_found = '0;
        for (int i = 0; i < NUM_CPU; i++) bus.addr_in[i*ADDR_W +: ADDR_W] = ADDR_W'(11'h100 + i);

        // Reset with every request raised: nothing may leak out.
        repeat (3) tick();
        @(negedge clk);
        check("reset_grant", bus.grant, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        bus.write_miss = '0;
        bus.invalidate = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Round-robin with all read misses held: 0,1,2,3,0.
        prev = '0; got = 0;
        for (int c = 0; c < 200 && got < 5; c++) begin
            @(negedge clk);
            if (bus.grant != 0 && prev == 0) begin
                check("grant_onehot", $onehot(bus.grant), 1);
                order[got] = bus.grant;
                got++;
            end
            prev = bus.grant;
        end
        if (got < 5) fail_timeout("rr_order");
        else begin
            check("rr_order0", order[0], 4'b0001);
            check("rr_order1", order[1], 4'b0010);
            check("rr_order2", order[2], 4'b0100);
            check("rr_order3", order[3], 4'b1000);
            check("rr_order4", order[4], 4'b0001);
        end
        tick();
        bus.read_miss = '0;
        wait_idle("rr_drain");

        // Snoop hit from core 3 (core 2's own found bit must be masked).
        tick();
        bus.read_miss[2] = 1'b1;
        bus.addr_in[2*ADDR_W +: ADDR_W] = 11'h1A4;
        bus.search_found = 4'b1100;
        observe("snoop_hit", n, n_search, search_v, n_ds, src_v, done_v, addr_v);
        check("hit_latency", n, 5);
        check("hit_search_cycles", n_search, 1);
        check("hit_search_val", search_v, 4'b1011);
        check("hit_xfer_cycles", n_ds, 2);
        check("hit_src_id", src_v, 3);
        check("hit_done", done_v, 4'b0100);
        check("hit_addr", addr_v, 11'h1A4);

        // Miss served by dmem; request dropped, address changed and op bits raised after latch.
        tick();
        bus.read_miss = '0;
        bus.search_found = 4'b0001;
        bus.read_miss[0] = 1'b1;
        bus.addr_in[0*ADDR_W +: ADDR_W] = 11'h2C3;
        tick();
        bus.read_miss[0] = 1'b0;
        bus.write_miss[0] = 1'b1;
        bus.addr_in[0*ADDR_W +: ADDR_W] = 11'h055;
        observe("mem_read", n, n_search, search_v, n_ds, src_v, done_v, addr_v);
        check("mem_latency_from_snoop", n, 6);
        check("mem_xfer_cycles", n_ds, 0);
        check("mem_done", done_v, 4'b0001);
        check("mem_addr", addr_v, 11'h2C3);

        // Write miss on core 1 and upgrade on core 3, raised together.
        tick();
        bus.write_miss = 4'b0010;
        bus.invalidate = 4'b1000;
        bus.search_found = '0;
        bus.addr_in[1*ADDR_W +: ADDR_W] = 11'h07F;
        bus.addr_in[3*ADDR_W +: ADDR_W] = 11'h155;
        tick();
        @(negedge clk);
        check("wm_inv_tag", bus.invalidate_tag, 4'b1101);
        check("wm_wback", bus.wback_dmem, 4'b0010);
        check("wm_done", bus.done, 4'b0010);
        check("wm_addr", bus.addr_out, 11'h07F);
        tick();
        bus.write_miss = '0;
        @(negedge clk);
        @(negedge clk);
        check("inv_tag", bus.invalidate_tag, 4'b0111);
        check("inv_dmem", bus.invalidate_dmem, 4'b1000);
        check("inv_done", bus.done, 4'b1000);
        tick();
        bus.invalidate = '0;

        // Write beats invalidate within one core.
        bus.write_miss[2] = 1'b1;
        bus.invalidate[2] = 1'b1;
        tick();
        bus.write_miss = '0;
        bus.invalidate = '0;
        @(negedge clk);
        check("prio_wback", bus.wback_dmem, 4'b0100);
        check("prio_inv_dmem", bus.invalidate_dmem, 4'b0000);

        // Reset in the second dmem wait cycle; rr_ptr must restart at 0 (was 3).
        tick();
        bus.read_miss[0] = 1'b1;
        repeat (4) tick();
        bus.read_miss = '0;
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_grant", bus.grant, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
`ifdef BUS_PERF_CNT_EN
        check("abort_txn_cnt", txn_cnt, 0);
`endif
        bus.read_miss = 4'b1010;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post_reset_grant", bus.grant, 4'b0010);
        tick();
        bus.read_miss = '0;
        wait_idle("post_reset_drain");
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog at %0t: simulation did not finish", $time);
        $fatal(1, "watchdog");
    end
endmodule
